// File: rtl/rand_stall_pkg.sv
// Shared types and defaults for the random-stall valid/ready buffer.
// The stall FSM encoding and stall-length clamping live here so tests and RTL agree.
package rand_stall_pkg;

  typedef enum logic {
    PASS  = 1'b0,
    STALL = 1'b1
  } state_t;

  localparam logic [7:0] OUT_THRESH_DEF = 8'd64;
  localparam logic [3:0] IN_THRESH_DEF  = 4'd4;
  localparam logic [3:0] MAX_STALL_DEF  = 4'd15;

  // A zero length field still produces a one-cycle stall.
  function automatic logic [3:0] clamp_len(input logic [3:0] raw,
                                           input logic [3:0] max_len);
    if (raw == 4'd0)
      return 4'd1;
    else if (raw > max_len)
      return max_len;
    else
      return raw;
  endfunction

endpackage

// File: rtl/rand_stall_fifo_if.sv
// Valid/ready payload channel; master drives valid/data, slave drives ready.
interface rand_stall_fifo_if #(
  parameter int DW = 64
);
  logic          valid;
  logic          ready;
  logic [DW-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/rand_stall_buf.sv
// Plain DP x DW registered FIFO with extended pointers; head is the oldest entry.
// Storage is not reset; only the pointers are.
module rand_stall_buf
  import rand_stall_pkg::*;
#(
  parameter int DW = 64,
  parameter int DP = 4
) (
  input  logic          CLK,
  input  logic          RSTn,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic          full,
  output logic          empty,
  output logic [DW-1:0] head
);

  localparam int AW = $clog2(DP);

  logic [DW-1:0] mem [DP];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/rand_stall_fifo.sv
// Valid/ready buffer that uses an external LFSR word to inject input back-pressure
// and output stall bursts; payload order and content are never disturbed.
module rand_stall_fifo
  import rand_stall_pkg::*;
#(
  parameter int         DW         = 64,
  parameter int         DP         = 4,
  parameter logic [7:0] OUT_THRESH = OUT_THRESH_DEF,
  parameter logic [3:0] IN_THRESH  = IN_THRESH_DEF,
  parameter logic [3:0] MAX_STALL  = MAX_STALL_DEF
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic [15:0]       random,
  input  logic              enable,
  rand_stall_fifo_if.slave  in_if,
  rand_stall_fifo_if.master out_if,
  output logic [31:0]       stall_cycles
);

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  state_t        state, state_nxt;
  logic [3:0]    cnt, cnt_nxt;
  logic          hold, hold_nxt;
  logic          hit;
  logic          vld;
  logic          full, empty;
  logic          push, pop;
  logic [DW-1:0] head;

  assign in_if.ready  = RSTn & !full & !(enable & (random[15:12] < IN_THRESH));
  assign push         = in_if.valid & in_if.ready;
  assign out_if.valid = RSTn & vld;
  assign out_if.data  = head;
  assign pop          = out_if.valid & out_if.ready;

  rand_stall_buf #(
    .DW (DW),
    .DP (DP)
  ) u_buf (
    .CLK   (CLK),
    .RSTn  (RSTn),
    .push  (push),
    .pop   (pop),
    .din   (in_if.data),
    .full  (full),
    .empty (empty),
    .head  (head)
  );

  // A pending handshake (hold) blocks new stalls so valid never retracts.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    hit       = 1'b0;
    vld       = 1'b0;
    case (state)
      PASS: begin
        hit = enable & !empty & !hold & (random[7:0] < OUT_THRESH);
        if (hit) begin
          state_nxt = STALL;
          cnt_nxt   = clamp_len(random[11:8], MAX_STALL);
        end else begin
          vld = !empty;
        end
      end
      STALL: begin
        cnt_nxt = cnt - 4'd1;
        if (!enable || cnt <= 4'd1) state_nxt = PASS;
      end
      default: state_nxt = PASS;
    endcase
  end

  always_comb begin
    hold_nxt = hold;
    if (pop)
      hold_nxt = 1'b0;
    else if (out_if.valid & !out_if.ready)
      hold_nxt = 1'b1;
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state        <= PASS;
      cnt          <= 4'd0;
      hold         <= 1'b0;
      stall_cycles <= 32'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      hold  <= hold_nxt;
      if (state == STALL) stall_cycles <= sat_inc(stall_cycles);
    end
  end

endmodule
